// File: rtl/im2col_row_sched.sv
// rtl/im2col_row_sched.sv - frame controller that streams sliding K-row bands to im2col
// Reads each image row once, keeps K line registers, advances the band one row per transfer.
module im2col_row_sched #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 3,
   parameter int DW    = 8,
   parameter int AW    = $clog2(IMG_H)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_abort,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_rd_en,
   output logic [AW-1:0]           o_rd_addr,
   input  logic [IMG_W*DW-1:0]     i_rd_data,
   output logic                    o_win_valid,
   input  logic                    i_win_ready,
   output logic [K*IMG_W*DW-1:0]   o_win_data,
   output logic [AW-1:0]           o_win_row
);

   localparam int RW = IMG_W * DW;
   localparam int SW = (K > 1) ? $clog2(K) : 1;
   localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - K);
   localparam logic [AW-1:0] BOT_OFS  = AW'(K - 1);
   localparam logic [AW-1:0] ONE      = AW'(1);
   localparam logic [SW-1:0] BOT_SLOT = SW'(K - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_LOAD,
      S_EMIT,
      S_FETCH,
      S_DONE
   } state_t;

   state_t          state;
   logic [RW-1:0]   line [K];
   logic            rd_en_d;
   logic [SW-1:0]   slot_d;
   logic [AW-1:0]   next_row;

   assign next_row = o_win_row + ONE;

   for (genvar r = 0; r < K; r++) begin : g_pack
      assign o_win_data[r*RW +: RW] = line[r];
   end

   always_ff @(posedge i_clk) begin
      // Abort behaves exactly like reset but only outside IDLE, and wins over a fire.
      if (i_rst || (i_abort && state != S_IDLE)) begin
         state       <= S_IDLE;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_rd_en     <= 1'b0;
         o_rd_addr   <= '0;
         o_win_valid <= 1'b0;
         o_win_row   <= '0;
         rd_en_d     <= 1'b0;
         slot_d      <= '0;
         for (int r = 0; r < K; r++) line[r] <= '0;
      end else begin
         rd_en_d <= o_rd_en;
         slot_d  <= (state == S_PRIME) ? SW'(o_rd_addr) : BOT_SLOT;
         if (rd_en_d) line[slot_d] <= i_rd_data;

         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state     <= S_PRIME;
                  o_busy    <= 1'b1;
                  o_rd_en   <= 1'b1;
                  o_rd_addr <= '0;
                  o_win_row <= '0;
               end
            end
            S_PRIME: begin
               if (o_rd_addr == BOT_OFS) begin
                  state     <= S_LOAD;
                  o_rd_en   <= 1'b0;
                  o_rd_addr <= '0;
               end else begin
                  o_rd_addr <= o_rd_addr + ONE;
               end
            end
            S_LOAD: begin
               state       <= S_EMIT;
               o_win_valid <= 1'b1;
            end
            S_EMIT: begin
               if (i_win_ready) begin
                  o_win_valid <= 1'b0;
                  o_win_row   <= next_row;
                  // Bottom line keeps its stale value until the fetched row lands in LOAD.
                  for (int r = 0; r < K - 1; r++) line[r] <= line[r+1];
                  if (o_win_row == LAST_ROW) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state     <= S_FETCH;
                     o_rd_en   <= 1'b1;
                     o_rd_addr <= next_row + BOT_OFS;
                  end
               end
            end
            S_FETCH: begin
               state     <= S_LOAD;
               o_rd_en   <= 1'b0;
               o_rd_addr <= '0;
            end
            S_DONE: begin
               state     <= S_IDLE;
               o_done    <= 1'b0;
               o_busy    <= 1'b0;
               o_win_row <= '0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_im2col_row_sched.sv
// tb/tb_im2col_row_sched.sv - scoreboard bench for im2col_row_sched
// Stimulus pushes expected reads/bands/done with cycle stamps; a monitor pops and compares.
module tb_im2col_row_sched;

   localparam int W   = 28;
   localparam int H   = 28;
   localparam int KK  = 3;
   localparam int DW  = 8;
   localparam int AW  = $clog2(H);
   localparam int RW  = W * DW;
   localparam int BW  = KK * RW;
   localparam int NB  = H - KK + 1;
   localparam int SH  = 3;
   localparam int SAW = $clog2(SH);

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic           clk;
   logic           rst;
   logic           start, abort, ready;
   logic           busy, done, rd_en, valid;
   logic [AW-1:0]  rd_addr, win_row;
   logic [RW-1:0]  rd_data;
   logic [BW-1:0]  win_data;

   logic           s_start, s_ready;
   logic           s_busy, s_done, s_rd_en, s_valid;
   logic [SAW-1:0] s_rd_addr, s_win_row;
   logic [RW-1:0]  s_rd_data;
   logic [BW-1:0]  s_win_data;

   int  pcnt;
   int  checks;
   int  failures;
   ev_t rd_q[$];
   ev_t band_q[$];
   int  done_q[$];

   im2col_row_sched #(.IMG_W(W), .IMG_H(H), .K(KK), .DW(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
      .i_rd_data(rd_data), .o_win_valid(valid), .i_win_ready(ready),
      .o_win_data(win_data), .o_win_row(win_row)
   );

   im2col_row_sched #(.IMG_W(W), .IMG_H(SH), .K(KK), .DW(DW)) dut_s (
      .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_abort(1'b0),
      .o_busy(s_busy), .o_done(s_done), .o_rd_en(s_rd_en), .o_rd_addr(s_rd_addr),
      .i_rd_data(s_rd_data), .o_win_valid(s_valid), .i_win_ready(s_ready),
      .o_win_data(s_win_data), .o_win_row(s_win_row)
   );

   function automatic logic [RW-1:0] row_pix(input int r);
      logic [RW-1:0] v;
      for (int c = 0; c < W; c++) v[c*DW +: DW] = DW'((r * W + c) % 256);
      return v;
   endfunction

   function automatic logic [BW-1:0] band_pix(input int n);
      logic [BW-1:0] b;
      for (int r = 0; r < KK; r++) b[r*RW +: RW] = row_pix(n + r);
      return b;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pcnt = 0;
   always @(posedge clk) pcnt <= pcnt + 1;

   always @(posedge clk) begin
      rd_data   <= row_pix(int'(rd_addr));
      s_rd_data <= row_pix(int'(s_rd_addr));
   end

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, pcnt, act, exp);
      end
   endtask

   task automatic push_frame(input int c, input int sb, input int sl, input int last, input bit wd);
      ev_t e;
      int  f;
      for (int i = 0; i < KK; i++) begin
         e.cyc = c + 1 + i; e.val = i; rd_q.push_back(e);
      end
      for (int n = 0; n <= last; n++) begin
         f = c + KK + 2 + 3 * n + ((n >= sb) ? sl : 0);
         e.cyc = f; e.val = n; band_q.push_back(e);
         if (n < last) begin
            e.cyc = f + 1; e.val = n + KK; rd_q.push_back(e);
         end else if (wd) begin
            done_q.push_back(f + 1);
         end
      end
   endtask

   task automatic wait_until(input int t);
      while (pcnt < t) @(negedge clk);
   endtask

   task automatic start_at(input int c);
      wait_until(c);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_busy"},  busy,     0);
      chk({nm, "_done"},  done,     0);
      chk({nm, "_rd_en"}, rd_en,    0);
      chk({nm, "_addr"},  rd_addr,  0);
      chk({nm, "_valid"}, valid,    0);
      chk({nm, "_row"},   win_row,  0);
      chk({nm, "_data"},  win_data, 0);
   endtask

   // Monitor: every read, fire and done must match the head of its queue.
   always @(negedge clk) begin
      ev_t e;
      int  d;
      #1;
      if (!rst) begin
         if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               e = rd_q.pop_front();
               chk("rd_addr", rd_addr, e.val);
               chk("rd_cyc", pcnt, e.cyc);
            end
         end else begin
            chk("rd_addr_idle", rd_addr, 0);
         end
         if (valid && ready) begin
            if (band_q.size() == 0) chk("fire_unexpected", 1, 0);
            else begin
               e = band_q.pop_front();
               chk("band_row", win_row, e.val);
               chk("band_cyc", pcnt, e.cyc);
               chk("band_data", win_data, band_pix(e.val));
            end
         end
         if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               d = done_q.pop_front();
               chk("done_cyc", pcnt, d);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout cyc=%0d", pcnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, nrd, nfire, ndone, fire_c, done_c;
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
      s_start = 1'b0; s_ready = 1'b1;
      wait_until(3);
      rst = 1'b0;
      #1 chk_idle("reset");

      // Full frame with ready held high.
      c = pcnt + 2;
      push_frame(c, NB, 0, NB - 1, 1'b1);
      start_at(c);
      wait_until(c + 81);
      #1 chk("busy_in_done", busy, 1);
      wait_until(c + 82);
      #1 chk("busy_after_frame", busy, 0);

      // Backpressure on band 3 for 10 cycles.
      c = pcnt + 2;
      push_frame(c, 3, 10, NB - 1, 1'b1);
      start_at(c);
      wait_until(c + 14);
      ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_valid", valid, 1);
         chk("bp_row", win_row, 3);
         chk("bp_data", win_data, band_pix(3));
         chk("bp_rd_en", rd_en, 0);
         @(negedge clk);
      end
      ready = 1'b1;
      wait_until(c + 92);

      // Start pulses while busy are ignored; the first IDLE cycle accepts one.
      c = pcnt + 2;
      push_frame(c, NB, 0, NB - 1, 1'b1);
      start_at(c);
      start_at(c + 2);
      start_at(c + 40);
      start_at(c + 81);
      c2 = c + 82;
      push_frame(c2, NB, 0, NB - 1, 1'b1);
      start_at(c2);
      wait_until(c2 + 82);

      // Reset held mid-EMIT, then a clean restart.
      c = pcnt + 2;
      ready = 1'b0;
      push_frame(c, NB, 0, -1, 1'b0);
      start_at(c);
      wait_until(c + 6);
      #1 chk("pre_rst_valid", valid, 1);
      rst = 1'b1;
      wait_until(c + 9);
      rst = 1'b0;
      #1 chk_idle("midrst");
      ready = 1'b1;
      c2 = c + 10;
      push_frame(c2, NB, 0, NB - 1, 1'b1);
      start_at(c2);
      wait_until(c2 + 82);

      // Abort coinciding with the fire of band 10.
      c = pcnt + 2;
      push_frame(c, NB, 0, 10, 1'b0);
      start_at(c);
      wait_until(c + 35);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1 chk_idle("abort");
      c2 = c + 37;
      push_frame(c2, NB, 0, NB - 1, 1'b1);
      start_at(c2);
      wait_until(c2 + 82);

      // Single-band configuration (IMG_H == K).
      c = pcnt + 2;
      nrd = 0; nfire = 0; ndone = 0; fire_c = -1; done_c = -1;
      wait_until(c);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (s_rd_en) begin
            chk("s_rd_addr", s_rd_addr, nrd);
            nrd++;
         end
         if (s_valid && s_ready) begin
            nfire++; fire_c = pcnt;
            chk("s_band_data", s_win_data, band_pix(0));
         end
         if (s_done) begin
            ndone++; done_c = pcnt;
         end
         @(negedge clk);
      end
      chk("s_reads", nrd, 3);
      chk("s_fires", nfire, 1);
      chk("s_fire_cyc", fire_c, c + 5);
      chk("s_dones", ndone, 1);
      chk("s_done_cyc", done_c, c + 6);
      chk("s_busy_end", s_busy, 0);

      repeat (3) @(negedge clk);
      chk("rd_q_empty", rd_q.size(), 0);
      chk("band_q_empty", band_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
